// File: rtl/cordic_dac_spi_12b.sv
// Samples the CORDIC sine/cosine pair on a periodic tick and ships it to a dual 12-bit DAC
// as two 16-bit SPI frames (A = sine, B = cosine), followed by a 2-clock LDAC strobe.
module cordic_dac_spi_12b #(
  parameter int width      = 12,
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 512,
  parameter bit SIGNED_IN  = 1'b1,
  parameter int CS_GAP     = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic [width-1:0] SINin,
  input  logic [width-1:0] COSin,
  output logic             dac_csn,
  output logic             dac_sclk,
  output logic             dac_sdi,
  output logic             dac_ldacn,
  output logic             busy,
  output logic             overrun
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int HALF_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int WAIT_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(SCLK_DIV - 1);
  localparam logic [WAIT_W-1:0] GAP_MAX  = WAIT_W'(CS_GAP - 1);
  localparam logic [WAIT_W-1:0] LDAC_MAX = WAIT_W'(1);
  localparam logic [11:0]       MSB_FLIP = SIGNED_IN ? 12'h800 : 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP,
    SHIFT_B,
    LDAC
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [11:0]         sin_field;
  logic [11:0]         cos_field;
  logic [11:0]         cos_hold;
  logic [15:0]         frame_a;
  logic [15:0]         frame_b;
  logic [15:0]         shift_reg;
  logic [15:0]         shift_n;
  logic [3:0]          bit_cnt;
  logic [3:0]          bit_n;
  logic [HALF_W-1:0]   half_cnt;
  logic [HALF_W-1:0]   half_n;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_n;
  logic                csn_n;
  logic                sclk_n;
  logic                sdi_n;
  logic                ldacn_n;

  // Offset-binary conversion of the top 12 bits of each CORDIC sample.
  assign sin_field = SINin[width-1 -: 12] ^ MSB_FLIP;
  assign cos_field = COSin[width-1 -: 12] ^ MSB_FLIP;
  assign frame_a   = {1'b0, 1'b0, 1'b1, 1'b1, sin_field};
  assign frame_b   = {1'b1, 1'b0, 1'b1, 1'b1, cos_hold};

  assign tick = enable && (div_cnt == DIV_MAX);
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // The sine sample lives in the shift register from the tick onward; cosine waits in cos_hold.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      half_cnt  <= '0;
      wait_cnt  <= '0;
      cos_hold  <= '0;
      dac_csn   <= 1'b1;
      dac_sclk  <= 1'b0;
      dac_sdi   <= 1'b0;
      dac_ldacn <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      half_cnt  <= half_n;
      wait_cnt  <= wait_n;
      dac_csn   <= csn_n;
      dac_sclk  <= sclk_n;
      dac_sdi   <= sdi_n;
      dac_ldacn <= ldacn_n;
      if (state == IDLE && tick) begin
        cos_hold <= cos_field;
      end
      if (state != IDLE && tick) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    bit_n   = bit_cnt;
    half_n  = half_cnt;
    wait_n  = wait_cnt;
    csn_n   = dac_csn;
    sclk_n  = dac_sclk;
    sdi_n   = dac_sdi;
    ldacn_n = dac_ldacn;

    case (state)
      IDLE: begin
        if (tick) begin
          state_n = SHIFT_A;
          shift_n = frame_a;
          bit_n   = 4'd15;
          half_n  = '0;
          csn_n   = 1'b0;
          sclk_n  = 1'b0;
          sdi_n   = frame_a[15];
        end
      end

      // A bit is SCLK_DIV clocks low then SCLK_DIV clocks high; data moves on the falling side.
      SHIFT_A, SHIFT_B: begin
        if (half_cnt == HALF_MAX) begin
          half_n = '0;
          if (!dac_sclk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 4'd0) begin
              csn_n  = 1'b1;
              wait_n = '0;
              if (state == SHIFT_A) begin
                state_n = GAP;
              end else begin
                state_n = LDAC;
                ldacn_n = 1'b0;
              end
            end else begin
              bit_n   = bit_cnt - 4'd1;
              shift_n = {shift_reg[14:0], 1'b0};
              sdi_n   = shift_reg[14];
            end
          end
        end else begin
          half_n = half_cnt + 1'b1;
        end
      end

      GAP: begin
        if (wait_cnt == GAP_MAX) begin
          state_n = SHIFT_B;
          shift_n = frame_b;
          bit_n   = 4'd15;
          half_n  = '0;
          csn_n   = 1'b0;
          sdi_n   = frame_b[15];
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end

      LDAC: begin
        if (wait_cnt == LDAC_MAX) begin
          state_n = IDLE;
          ldacn_n = 1'b1;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
